// File: rtl/isp_pkg.sv
// isp_pkg: shared widths for the gamma/dither requantizer stage.
package isp_pkg;
  localparam int DW_IN      = 12;
  localparam int DW_OUT     = 8;
  localparam int FRAC       = DW_IN - DW_OUT;
  localparam int CLIP_CNT_W = 16;
endpackage

// File: rtl/gamma_dither_ch.sv
// gamma_dither_ch: one channel of round/error-diffuse requantization with saturation.
module gamma_dither_ch #(
  parameter int DW_IN  = isp_pkg::DW_IN,
  parameter int DW_OUT = isp_pkg::DW_OUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              de_i,
  input  logic              mode_i,
  input  logic [DW_IN-1:0]  data_i,
  output logic [DW_OUT-1:0] data_o,
  output logic              sat_o
);
  localparam int FRAC = DW_IN - DW_OUT;
  localparam logic [DW_IN:0] HALF = (DW_IN+1)'(2 ** (FRAC - 1));
  logic [FRAC-1:0]   err_q, err_d;
  logic [DW_OUT-1:0] data_q, data_d;
  logic [DW_IN:0]    sum;
  logic [DW_OUT:0]   res;
  always_comb begin
    sum    = {1'b0, data_i} + (mode_i ? {{(DW_IN + 1 - FRAC){1'b0}}, err_q} : HALF);
    res    = sum[DW_IN:FRAC];
    sat_o  = de_i & res[DW_OUT];
    data_d = !de_i ? '0 : res[DW_OUT] ? '1 : res[DW_OUT-1:0];
    // err is cleared outside active video and on saturation so each line starts clean
    err_d  = (de_i & mode_i & ~res[DW_OUT]) ? sum[FRAC-1:0] : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q  <= '0;
      data_q <= '0;
    end else begin
      err_q  <= err_d;
      data_q <= data_d;
    end
  end
  assign data_o = data_q;
endmodule

// File: rtl/gamma_dither.sv
// gamma_dither: 2-cycle requantizer (round or error diffusion) with per-frame clip counter.
module gamma_dither #(
  parameter int DW_IN  = isp_pkg::DW_IN,
  parameter int DW_OUT = isp_pkg::DW_OUT
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic                          I_vs,
  input  logic                          I_hs,
  input  logic                          I_de,
  input  logic [DW_IN-1:0]              I_r_data,
  input  logic [DW_IN-1:0]              I_g_data,
  input  logic [DW_IN-1:0]              I_b_data,
  input  logic                          I_dither_en,
  output logic                          O_vs,
  output logic                          O_hs,
  output logic                          O_de,
  output logic [DW_OUT-1:0]             O_r_data,
  output logic [DW_OUT-1:0]             O_g_data,
  output logic [DW_OUT-1:0]             O_b_data,
  output logic [isp_pkg::CLIP_CNT_W-1:0] O_clip_cnt
);
  localparam int CW = isp_pkg::CLIP_CNT_W;
  logic [DW_IN-1:0]  din  [3];
  logic [DW_OUT-1:0] dout [3];
  logic [2:0]        sat, tim_q;
  logic              vs_q, vs_rise, mode_q, mode_d, inc;
  logic [CW-1:0]     cnt_q, cnt_d, clip_q, clip_d, cnt_inc;
  assign din = '{I_r_data, I_g_data, I_b_data};
  for (genvar i = 0; i < 3; i++) begin : g_ch
    gamma_dither_ch #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) u_ch (
      .clk_i (I_clk),
      .rst_i (I_rst),
      .de_i  (I_de),
      .mode_i(mode_q),
      .data_i(din[i]),
      .data_o(dout[i]),
      .sat_o (sat[i])
    );
  end
  always_comb begin
    vs_rise = I_vs & ~vs_q;
    inc     = |sat && cnt_q != '1;
    cnt_inc = cnt_q + CW'(inc);
    mode_d  = vs_rise ? I_dither_en : mode_q;
    // a clip landing on the vs-rise cycle still belongs to the frame being reported
    cnt_d   = vs_rise ? '0 : cnt_inc;
    clip_d  = vs_rise ? cnt_inc : clip_q;
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      vs_q     <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      clip_q   <= '0;
      tim_q    <= '0;
      O_vs     <= 1'b0;
      O_hs     <= 1'b0;
      O_de     <= 1'b0;
      O_r_data <= '0;
      O_g_data <= '0;
      O_b_data <= '0;
    end else begin
      vs_q     <= I_vs;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      clip_q   <= clip_d;
      tim_q    <= {I_vs, I_hs, I_de};
      O_vs     <= tim_q[2];
      O_hs     <= tim_q[1];
      O_de     <= tim_q[0];
      O_r_data <= dout[0];
      O_g_data <= dout[1];
      O_b_data <= dout[2];
    end
  end
  assign O_clip_cnt = clip_q;
endmodule

// File: tb/tb_gamma_dither.sv
// tb_gamma_dither: directed + random stimulus against an arithmetic requantization model.
module tb_gamma_dither;
  logic        I_clk = 0, I_rst = 1, I_vs = 0, I_hs = 0, I_de = 0, I_dither_en = 0;
  logic [11:0] I_r_data = 0, I_g_data = 0, I_b_data = 0;
  logic        O_vs, O_hs, O_de;
  logic [7:0]  O_r_data, O_g_data, O_b_data;
  logic [15:0] O_clip_cnt;
  int total = 0, bad = 0;
  int err [3], mode, cnt, clip_exp, vsp;
  int pv [6], cv [6];
  int r_log [$];

  gamma_dither dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_vs(I_vs), .I_hs(I_hs), .I_de(I_de),
    .I_r_data(I_r_data), .I_g_data(I_g_data), .I_b_data(I_b_data),
    .I_dither_en(I_dither_en), .O_vs(O_vs), .O_hs(O_hs), .O_de(O_de),
    .O_r_data(O_r_data), .O_g_data(O_g_data), .O_b_data(O_b_data),
    .O_clip_cnt(O_clip_cnt)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, act, exp, $time);
    end
  endtask

  // model: plain integer arithmetic on the requantization rules
  always @(posedge I_clk) begin
    if (I_rst) begin
      err = '{0, 0, 0};
      mode = 0; cnt = 0; clip_exp = 0; vsp = 0;
      pv = '{0, 0, 0, 0, 0, 0};
      cv = '{0, 0, 0, 0, 0, 0};
    end else begin
      int in [3];
      int s, o, e, clipped;
      pv = cv;
      in = '{int'(I_r_data), int'(I_g_data), int'(I_b_data)};
      clipped = 0;
      cv[0] = I_vs; cv[1] = I_hs; cv[2] = I_de;
      for (int c = 0; c < 3; c++) begin
        s = in[c] + (mode ? err[c] : 8);
        o = s / 16;
        e = s % 16;
        if (o > 255) begin
          o = 255; e = 0;
          if (I_de) clipped = 1;
        end
        cv[3 + c] = I_de ? o : 0;
        err[c] = (I_de && mode) ? e : 0;
      end
      if (I_vs && !vsp) begin
        clip_exp = (cnt + clipped > 65535) ? 65535 : cnt + clipped;
        cnt = 0;
        mode = I_dither_en;
      end else
        cnt = (cnt + clipped > 65535) ? 65535 : cnt + clipped;
      vsp = I_vs;
    end
    #1;
    chk("O_vs", O_vs, pv[0]);
    chk("O_hs", O_hs, pv[1]);
    chk("O_de", O_de, pv[2]);
    chk("O_r_data", O_r_data, pv[3]);
    chk("O_g_data", O_g_data, pv[4]);
    chk("O_b_data", O_b_data, pv[5]);
    chk("O_clip_cnt", O_clip_cnt, clip_exp);
    if (O_de) r_log.push_back(int'(O_r_data));
  end

  task automatic drive(input logic vs, hs, de, input logic [11:0] r, g, b);
    @(negedge I_clk);
    I_vs = vs; I_hs = hs; I_de = de;
    I_r_data = r; I_g_data = g; I_b_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1, 0, 0, 0, 0);
  endtask

  task automatic vsync();
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input logic [11:0] r, input int n);
    repeat (n) drive(0, 0, 1, r, 12'd0, 12'd0);
  endtask

  task automatic chk_log(input string n, input int idx, input int exp);
    chk(n, (idx < r_log.size()) ? r_log[idx] : -1, exp);
  endtask

  initial begin
    repeat (4) drive(0, 0, 1, 12'd4095, 12'd4095, 12'd4095);
    chk("rst_o_de", O_de, 0);
    chk("rst_o_r", O_r_data, 0);
    chk("rst_o_clip", O_clip_cnt, 0);
    @(negedge I_clk) I_rst = 0;
    @(posedge I_clk) #2 chk("rel_de_1", O_de, 0);
    @(posedge I_clk) #2 chk("rel_de_2", O_de, 1);
    idle(3);
    I_dither_en = 0;
    vsync();
    r_log.delete();
    pix(12'd2040, 1); pix(12'd4092, 1); idle(3);
    chk_log("round_p0", 0, 128);
    chk_log("round_p1", 1, 255);
    vsync();
    chk("round_clip", O_clip_cnt, 1);
    I_dither_en = 1;
    vsync();
    chk("empty_clip", O_clip_cnt, 0);
    r_log.delete();
    pix(12'd2056, 6); idle(4); pix(12'd2056, 6); idle(3);
    for (int i = 0; i < 6; i++) chk_log("dither_seq", i, (i % 2) ? 129 : 128);
    chk_log("dither_line2", 6, 128);
    I_dither_en = 0;
    r_log.delete();
    pix(12'd2056, 2); idle(3);
    chk_log("latch_hold0", 0, 128);
    chk_log("latch_hold1", 1, 129);
    vsync();
    r_log.delete();
    pix(12'd2056, 2); idle(3);
    chk_log("latch_new0", 0, 129);
    chk_log("latch_new1", 1, 129);
    I_dither_en = 1;
    vsync();
    r_log.delete();
    pix(12'd4092, 3); idle(3);
    for (int i = 0; i < 3; i++) chk_log("clip_dither_out", i, 255);
    I_dither_en = 0;
    vsync();
    chk("clip_dither_cnt", O_clip_cnt, 1);
    pix(12'd4092, 3); idle(3);
    vsync();
    chk("clip_round_cnt", O_clip_cnt, 3);
    pix(12'd4095, 70000); idle(3);
    vsync();
    chk("clip_sat_cnt", O_clip_cnt, 65535);
    pix(12'd100, 20); idle(3);
    vsync();
    chk("clip_zero_cnt", O_clip_cnt, 0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [11:0] d [3];
      for (int c = 0; c < 3; c++)
        d[c] = $urandom_range(0, 1) ? 12'($urandom_range(3900, 4095)) : 12'($urandom_range(0, 4095));
      drive((cyc % 400) < 3, $urandom_range(0, 1) == 1,
            (cyc % 400) >= 10 && (cyc % 40) >= 8 && $urandom_range(0, 7) != 0, d[0], d[1], d[2]);
      if ($urandom_range(0, 49) == 0) I_dither_en = $urandom_range(0, 1) == 1;
      I_rst = $urandom_range(0, 499) == 0;
    end
    I_rst = 0;
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gamma_dither.md
GAMMA_DITHER -- requirements
Module: gamma_dither

Interface
REQ-001 SHALL have parameter DW_IN, default 12, width of the gamma-corrected input component.
REQ-002 SHALL have parameter DW_OUT, default 8, width of the requantized output component; FRAC = DW_IN-DW_OUT (4).
REQ-003 SHALL have port I_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port I_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports I_vs, I_hs, I_de, input, 1 each: video timing from the gamma stage.
REQ-006 SHALL have ports I_r_data, I_g_data, I_b_data, input, DW_IN each: gamma-corrected components, valid when I_de=1.
REQ-007 SHALL have port I_dither_en, input, 1: 1 selects error diffusion, 0 selects round-to-nearest.
REQ-008 SHALL have ports O_vs, O_hs, O_de, output, 1 each: timing delayed to match the data.
REQ-009 SHALL have ports O_r_data, O_g_data, O_b_data, output, DW_OUT each: requantized components.
REQ-010 SHALL have port O_clip_cnt, output, 16: count of clipped pixels in the previous completed frame.

Function
REQ-011 SHALL have a fixed latency of 2 I_clk cycles from I_vs/I_hs/I_de/I_*_data to the corresponding O_* signals.
REQ-012 SHALL sample I_dither_en into frame_mode on each I_vs rising edge (I_vs=1, previous I_vs=0) only; it holds for the whole frame.
REQ-013 SHALL, per channel with frame_mode=0, compute sum = in + 2^(FRAC-1); the output is sum>>FRAC.
REQ-014 SHALL, per channel with frame_mode=1, compute sum = in + err, where err is a FRAC-bit register; the output is sum>>FRAC and err_next = sum[FRAC-1:0].
REQ-015 SHALL saturate any result above 2^DW_OUT-1 to 2^DW_OUT-1 (255); on saturation err_next = 0.
REQ-016 SHALL update err only in cycles with I_de=1, and force err to 0 in every cycle with I_de=0, so every line starts with err=0.
REQ-017 SHALL drive O_*_data to 0 whenever O_de=0.
REQ-018 SHALL flag a pixel as clipped when any of its three channels saturated (pre-saturation result > 255).
REQ-019 SHALL count clipped pixels in frame_cnt (16 bit, saturating at 65535, no wrap).
REQ-020 SHALL, on an I_vs rising edge, load O_clip_cnt with frame_cnt (including a clipped pixel in that same cycle if one exists) and clear frame_cnt to 0.
REQ-021 SHALL process only I_vs/I_de edges; I_hs is delayed only and is never interpreted.

Reset
REQ-022 SHALL, while I_rst=1, set all outputs to 0, err registers to 0, frame_mode to 0, frame_cnt to 0, and edge-detect history to 0.
REQ-023 SHALL, when reset is asserted mid-line, force outputs to 0 on the next edge; after release the first O_de=1 appears 2 cycles after the first I_de=1.

Structure
REQ-024 SHALL place DW_IN, DW_OUT, FRAC and CLIP_CNT_W=16 in shared package isp_pkg.
REQ-025 SHALL implement one channel's round/diffuse/saturate/err register as sub-module gamma_dither_ch, instantiated three times; timing delay, edge detect, frame_mode and clip counter live in the top.
REQ-026 SHALL be implemented in roughly 150-250 lines total, with no RAM and no multipliers.

Verification
REQ-027 Reset: hold I_rst=1 with I_de=1 and data 4095 -> all outputs 0; release -> O_de follows I_de 2 cycles later.
REQ-028 Round mode: I_dither_en=0 before vs; inputs 2040 and then 4092 -> outputs 128 and then 255; the second pixel counts as clipped.
REQ-029 Dither mode: I_dither_en=1, constant input 2056 for 6 pixels -> outputs 128,129,128,129,128,129; hblank, then the same line again -> first output is 128 (err cleared).
REQ-030 Mode latch: toggle I_dither_en mid-frame -> no output change until the next I_vs rise; after it, the new mode applies.
REQ-031 Clip count: frame with R=4092 on 3 consecutive pixels, dither on -> outputs 255,255,255; O_clip_cnt = 1 after the next vs rise. Repeat with dither off -> O_clip_cnt = 3.
REQ-032 Counter saturation: 70000 clipped pixels in one frame -> O_clip_cnt = 65535; the following frame has no clips -> O_clip_cnt = 0.
